// File: rtl/xadc_drp_scheduler.sv
// XADC DRP read scheduler: once per sample frame, reads the EMG (VAUX3) and/or
// ECG (VAUX11) status registers over DRP and publishes the 12-bit results.
module xadc_drp_scheduler #(
    parameter int          SAMPLE_DIV   = 1000,
    parameter int          DRDY_TIMEOUT = 64,
    parameter logic [6:0]  EMG_ADDR     = 7'h13,
    parameter logic [6:0]  ECG_ADDR     = 7'h1B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ch_enable,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic        drp_dwe,
    output logic [31:0] emg_out,
    output logic [31:0] ecg_out,
    output logic        emg_valid,
    output logic        ecg_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TO_W  = $clog2(DRDY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    logic [CNT_W-1:0] r_frame_cnt;
    logic [1:0]       r_state;
    logic             r_sel;        // 0 = EMG, 1 = ECG
    logic             r_ecg_pend;   // ECG still to be read after EMG this frame
    logic [TO_W-1:0]  r_wcnt;
    logic [11:0]      r_data;
    logic [6:0]       r_daddr;
    logic [31:0]      r_emg_out;
    logic [31:0]      r_ecg_out;
    logic             r_emg_valid;
    logic             r_ecg_valid;
    logic             r_timeout;
    logic             r_overrun;

    logic w_tick;
    logic w_more;
    logic w_unused;

    assign w_tick   = (r_frame_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign w_more   = !r_sel && r_ecg_pend;
    // Low nibble of the XADC result is below the 12-bit resolution.
    assign w_unused = ^drp_do[3:0];

    // Free-running frame counter; the wrap cycle is the frame tick.
    always_ff @(posedge clk) begin
        if (reset)       r_frame_cnt <= '0;
        else if (w_tick) r_frame_cnt <= '0;
        else             r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    // Channel sequencing FSM, DRP handshake, result registers and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_ecg_pend  <= 1'b0;
            r_wcnt      <= '0;
            r_data      <= '0;
            r_daddr     <= EMG_ADDR;
            r_emg_out   <= '0;
            r_ecg_out   <= '0;
            r_emg_valid <= 1'b0;
            r_ecg_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_emg_valid <= 1'b0;
            r_ecg_valid <= 1'b0;
            // A tick while a frame is in flight is dropped and flagged.
            if (w_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && ch_enable != 2'b00) begin
                        r_sel      <= !ch_enable[0];
                        r_ecg_pend <= ch_enable[0] & ch_enable[1];
                        r_daddr    <= ch_enable[0] ? EMG_ADDR : ECG_ADDR;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wcnt  <= TO_W'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // drdy wins over a timeout landing on the same cycle.
                    if (drp_drdy) begin
                        r_data  <= drp_do[15:4];
                        r_state <= S_STORE;
                    end else if (r_wcnt == TO_W'(DRDY_TIMEOUT)) begin
                        r_timeout <= 1'b1;
                        if (w_more) begin
                            r_sel   <= 1'b1;
                            r_daddr <= ECG_ADDR;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: begin
                    if (!r_sel) begin
                        r_emg_out   <= {20'h0, r_data};
                        r_emg_valid <= 1'b1;
                    end else begin
                        r_ecg_out   <= {20'h0, r_data};
                        r_ecg_valid <= 1'b1;
                    end
                    if (w_more) begin
                        r_sel   <= 1'b1;
                        r_daddr <= ECG_ADDR;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign drp_den     = (r_state == S_ISSUE);
    assign drp_daddr   = r_daddr;
    assign drp_dwe     = 1'b0;
    assign emg_out     = r_emg_out;
    assign ecg_out     = r_ecg_out;
    assign emg_valid   = r_emg_valid;
    assign ecg_valid   = r_ecg_valid;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout;
    assign overrun_err = r_overrun;

endmodule
